// File: rtl/branch_commit_queue.sv
// First-word-fall-through commit queue between one execution branch and the commit stage.
// Pointers carry one extra wrap bit so that full and empty can be told apart without a separate counter.
module branch_commit_queue #(
    parameter int data_width = 16,
    parameter int n_blocks   = 256,
    parameter int depth      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(n_blocks)-1:0]   block_in,
    input  logic [2*data_width-1:0]       result,
    input  logic [3:0]                    dest,
    input  logic [8:0]                    commit_id,
    input  logic                          commit_flag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(n_blocks)-1:0]   block_out,
    output logic [2*data_width-1:0]       result_out,
    output logic [3:0]                    dest_out,
    output logic [8:0]                    commit_id_out,
    output logic                          commit_flag_out,
    output logic [$clog2(depth):0]        count,
    output logic                          overflow
);
    localparam int AW = $clog2(depth);
    localparam int BW = $clog2(n_blocks);
    localparam int RW = 2 * data_width;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef struct packed {
        logic [BW-1:0] blk;
        logic [RW-1:0] res;
        logic [3:0]    dst;
        logic [8:0]    cid;
        logic          flg;
    } entry_t;

    entry_t      r_mem [depth];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_overflow;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    entry_t      w_head;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Handshake: a beat transfers on a clk edge exactly when valid && ready are both high;
    // in_ready never depends on out_ready, and both sides read 0 while reset or !enable.
    assign in_ready  = reset && enable && !flush && !w_full;
    assign out_valid = reset && enable && !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign count    = r_wr_ptr - r_rd_ptr;
    assign overflow = r_overflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (enable && in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            // Flush wins over any push or pop requested in the same cycle.
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is not reset; only slots behind the write pointer are ever presented.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= '{blk: block_in, res: result, dst: dest,
                                         cid: commit_id, flg: commit_flag};
        end
    end

    assign w_head          = r_mem[r_rd_ptr[AW-1:0]];
    assign block_out       = w_head.blk;
    assign result_out      = w_head.res;
    assign dest_out        = w_head.dst;
    assign commit_id_out   = w_head.cid;
    assign commit_flag_out = w_head.flg;

endmodule

// File: tb/tb_branch_commit_queue.sv
// Directed table of per-cycle vectors for branch_commit_queue, plus a hand-written asynchronous reset sequence.
module tb_branch_commit_queue;
    logic        clk;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  block_in;
    logic [31:0] result;
    logic [3:0]  dest;
    logic [8:0]  commit_id;
    logic        commit_flag;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  block_out;
    logic [31:0] result_out;
    logic [3:0]  dest_out;
    logic [8:0]  commit_id_out;
    logic        commit_flag_out;
    logic [2:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    branch_commit_queue #(.data_width(16), .n_blocks(256), .depth(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .result(result), .dest(dest),
        .commit_id(commit_id), .commit_flag(commit_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .block_out(block_out), .result_out(result_out), .dest_out(dest_out),
        .commit_id_out(commit_id_out), .commit_flag_out(commit_flag_out),
        .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       fl;
        logic       iv;
        logic       ordy;
        logic [8:0] id;
        logic [2:0] e_cnt;
        logic       e_irdy;
        logic       e_ovld;
        logic       e_ovf;
        logic [8:0] e_head;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_payload(input logic [8:0] id);
        commit_id   = id;
        block_in    = id[7:0];
        dest        = id[3:0];
        commit_flag = id[0];
        result      = {23'd0, id};
    endtask

    task automatic set_vec(input int i, input logic en, input logic fl, input logic iv,
                           input logic ordy, input logic [8:0] id, input logic [2:0] cnt,
                           input logic irdy, input logic ovld, input logic ovf,
                           input logic [8:0] head);
        vecs[i] = '{en: en, fl: fl, iv: iv, ordy: ordy, id: id, e_cnt: cnt,
                    e_irdy: irdy, e_ovld: ovld, e_ovf: ovf, e_head: head};
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_payload(9'd0);

        //        i   en fl iv or  id  cnt irdy ovld ovf head
        set_vec( 0, 1, 0, 1, 0,  5, 0, 1, 0, 0, 0);   // fill 5,6,7,8
        set_vec( 1, 1, 0, 1, 0,  6, 1, 1, 1, 0, 5);
        set_vec( 2, 1, 0, 1, 0,  7, 2, 1, 1, 0, 5);
        set_vec( 3, 1, 0, 1, 0,  8, 3, 1, 1, 0, 5);
        set_vec( 4, 1, 0, 0, 0,  0, 4, 0, 1, 0, 5);   // full, head stable
        set_vec( 5, 1, 0, 0, 1,  0, 4, 0, 1, 0, 5);   // drain
        set_vec( 6, 1, 0, 0, 1,  0, 3, 1, 1, 0, 6);
        set_vec( 7, 1, 0, 0, 1,  0, 2, 1, 1, 0, 7);
        set_vec( 8, 1, 0, 0, 1,  0, 1, 1, 1, 0, 8);
        set_vec( 9, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        set_vec(10, 1, 0, 1, 0,  1, 0, 1, 0, 0, 0);
        set_vec(11, 1, 0, 1, 0,  2, 1, 1, 1, 0, 1);
        set_vec(12, 1, 0, 1, 1,  9, 2, 1, 1, 0, 1);   // push 9 + pop 1
        set_vec(13, 1, 0, 0, 0,  0, 2, 1, 1, 0, 2);
        set_vec(14, 0, 0, 1, 1,  3, 2, 0, 0, 0, 0);   // disabled: frozen
        set_vec(15, 1, 0, 0, 0,  0, 2, 1, 1, 0, 2);
        set_vec(16, 1, 0, 1, 0, 10, 2, 1, 1, 0, 2);
        set_vec(17, 1, 0, 1, 0, 11, 3, 1, 1, 0, 2);
        set_vec(18, 1, 0, 1, 0, 12, 4, 0, 1, 0, 2);   // in_valid while full
        set_vec(19, 1, 0, 1, 1, 12, 4, 0, 1, 1, 2);   // full + out_ready: pop only
        set_vec(20, 1, 0, 0, 0,  0, 3, 1, 1, 1, 9);
        set_vec(21, 1, 1, 1, 0, 13, 3, 0, 1, 1, 9);   // flush with in_valid
        set_vec(22, 1, 0, 0, 0,  0, 0, 1, 0, 1, 0);

        #2;
        check("reset_count", 32'(count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 23; i++) begin
            enable    = vecs[i].en;
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            drive_payload(vecs[i].id);
            #3;
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_irdy));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ovld));
            check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
            if (vecs[i].e_ovld) begin
                check($sformatf("v%0d_commit_id", i), 32'(commit_id_out), 32'(vecs[i].e_head));
                check($sformatf("v%0d_result", i), result_out, {23'd0, vecs[i].e_head});
                check($sformatf("v%0d_side", i),
                      32'({block_out, dest_out, commit_flag_out}),
                      32'({vecs[i].e_head[7:0], vecs[i].e_head[3:0], vecs[i].e_head[0]}));
            end
            @(posedge clk); #1;
        end

        // Reset mid-push at count=2, then first push after release must reach the head.
        enable = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        drive_payload(9'd20);
        @(posedge clk); #1;
        drive_payload(9'd21);
        @(posedge clk); #1;
        check("pre_reset_count", 32'(count), 32'd2);
        drive_payload(9'd22);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_count", 32'(count), 32'd0);
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        check("async_reset_in_ready", 32'(in_ready), 32'd0);
        check("async_reset_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        check("held_reset_count", 32'(count), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        drive_payload(9'd30);
        result = 32'h0001_8000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        check("post_reset_count", 32'(count), 32'd1);
        check("post_reset_out_valid", 32'(out_valid), 32'd1);
        check("post_reset_result", result_out, 32'h0001_8000);
        check("post_reset_commit_id", 32'(commit_id_out), 32'd30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_commit_queue.md
BRANCH_COMMIT_QUEUE -- requirements
Module: branch_commit_queue

Parameters
REQ-001 SHALL have parameter data_width, default 16, meaning sample/channel word width; results are 2*data_width.
REQ-002 SHALL have parameter n_blocks, default 256, meaning number of pipeline blocks; block field width is $clog2(n_blocks).
REQ-003 SHALL have parameter depth, default 4, meaning queue entries; legal values are powers of two, 2..16.

Interface
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is posedge clk.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: when low, no push and no pop occur.
REQ-007 SHALL have port flush, input, 1 bit: synchronous queue clear.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): producer-side handshake from one execution branch.
REQ-009 SHALL have producer-side payload inputs: block_in ($clog2(n_blocks)), result (2*data_width), dest (4), commit_id (9), commit_flag (1).
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): commit-side handshake toward the commit stage.
REQ-011 SHALL have commit-side payload outputs block_out, result_out, dest_out, commit_id_out, commit_flag_out, each the same width as its input.
REQ-012 SHALL have port count, output, $clog2(depth)+1 bits: current occupancy.
REQ-013 SHALL have port overflow, output, 1 bit: sticky protocol-error flag.

Function
REQ-014 SHALL store entries in FIFO order using read and write pointers of $clog2(depth)+1 bits; full = pointers differ only in MSB; empty = pointers equal.
REQ-015 SHALL drive in_ready = enable && !flush && !full; it SHALL be combinational from registered state plus enable/flush only, never from out_ready.
REQ-016 SHALL push on a clk edge when in_valid && in_ready, writing all five payload fields together into the write-pointer slot and incrementing the write pointer modulo 2*depth.
REQ-017 SHALL be first-word-fall-through: out_valid = enable && !empty, and the payload outputs SHALL present the head entry in the same cycle it becomes valid, with zero added latency.
REQ-018 SHALL pop on a clk edge when out_valid && out_ready, incrementing the read pointer.
REQ-019 SHALL hold the payload outputs stable while out_valid && !out_ready.
REQ-020 SHALL allow a simultaneous push and pop in one cycle when not full; count is then unchanged.
REQ-021 SHALL not push when full, even if out_ready is high that cycle; entry is accepted the next cycle.
REQ-022 SHALL, when flush is high, set both pointers to 0 on that edge; flush SHALL take priority over push and pop in that cycle, and overflow SHALL be unaffected.
REQ-023 SHALL set overflow to 1 when in_valid is high while full and enable is high; overflow SHALL hold until reset.
REQ-024 SHALL keep count equal to write pointer minus read pointer, ranging 0..depth.
REQ-025 SHALL, when enable is low, freeze the pointers and storage and hold in_ready and out_valid at 0.

Reset
REQ-026 SHALL, while reset is low, asynchronously clear both pointers, count and overflow, and SHALL drive in_ready=0 and out_valid=0; storage contents need not be cleared.
REQ-027 SHALL let an asserted reset abort any in-flight push or pop; after release the first push SHALL land in slot 0.

Verification
REQ-028 SHALL be verified by this fill test: enable=1, depth=4, push ids 5,6,7,8 with out_ready=0 -> count=4, in_ready=0, and commit_id_out=5.
REQ-029 SHALL be verified by this drain test: from full, out_ready=1 for 4 cycles -> ids 5,6,7,8 pop in order, then out_valid=0 and count=0.
REQ-030 SHALL be verified by this simultaneous push/pop test: count=2, push id 9 and pop in the same cycle -> count stays 2 and the head advances.
REQ-031 SHALL be verified by this overflow test: full, then in_valid=1 -> overflow=1 and count=4; overflow stays 1 after a later pop.
REQ-032 SHALL be verified by this flush test: count=3, flush=1 with in_valid=1 -> count=0, out_valid=0, and nothing is pushed.
REQ-033 SHALL be verified by this reset test: reset low mid-push at count=2 -> count=0 and out_valid=0 immediately, without waiting for a clk edge; after release, a push of result=32'h0001_8000 appears on result_out.
